// File: rtl/id_stage.sv
// id_stage: IF/ID latch with two-state FSM, field decode, branch/jump targets and 2R1W register file.
// Optional macro ID_WB_BYPASS_EN forwards same-cycle write-back data to the read ports.
`ifndef PC_WIDTH
`define PC_WIDTH 32
`endif
`ifndef NOP_INSTRUCTION
`define NOP_INSTRUCTION 32'h0000_0000
`endif

module id_stage #(
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [31:0]               instruction,
    input  logic [`PC_WIDTH-1:0]      next_pc,
    input  logic                      if_valid,
    input  logic                      stall,
    input  logic                      flush,
    input  logic                      wb_en,
    input  logic [REG_ADDR_WIDTH-1:0] wb_addr,
    input  logic [31:0]               wb_data,
    output logic                      id_valid,
    output logic [`PC_WIDTH-1:0]      id_pc,
    output logic [5:0]                opcode,
    output logic [4:0]                rs_addr,
    output logic [4:0]                rt_addr,
    output logic [4:0]                rd_addr,
    output logic [31:0]               rs_data,
    output logic [31:0]               rt_data,
    output logic [31:0]               imm_ext,
    output logic [`PC_WIDTH-1:0]      branch_addr,
    output logic [`PC_WIDTH-1:0]      jump_addr
);
    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    logic        state;
    logic [31:0] id_instr;
    logic [31:0] regs [2**REG_ADDR_WIDTH];
    logic [REG_ADDR_WIDTH-1:0] rs_idx, rt_idx;
    logic [31:0] rs_reg, rt_reg;

    // flush beats stall; an idle fetch inserts a bubble but keeps the old pc
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            id_instr <= `NOP_INSTRUCTION;
            id_pc    <= '0;
        end else if (flush) begin
            state    <= EMPTY;
            id_instr <= `NOP_INSTRUCTION;
        end else if (!stall) begin
            state    <= if_valid ? FULL : EMPTY;
            id_instr <= if_valid ? instruction : `NOP_INSTRUCTION;
            if (if_valid) id_pc <= next_pc;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 2**REG_ADDR_WIDTH; i++) regs[i] <= '0;
        end else if (wb_en && wb_addr != '0) begin
            regs[wb_addr] <= wb_data;
        end
    end

    assign id_valid    = state == FULL;
    assign opcode      = id_instr[31:26];
    assign rs_addr     = id_instr[25:21];
    assign rt_addr     = id_instr[20:16];
    assign rd_addr     = id_instr[15:11];
    assign imm_ext     = {{16{id_instr[15]}}, id_instr[15:0]};
    assign branch_addr = id_pc + `PC_WIDTH'(imm_ext);
    assign jump_addr   = `PC_WIDTH'({6'b0, id_instr[25:0]});
    assign rs_idx      = REG_ADDR_WIDTH'(rs_addr);
    assign rt_idx      = REG_ADDR_WIDTH'(rt_addr);
    assign rs_reg      = rs_idx == '0 ? 32'h0 : regs[rs_idx];
    assign rt_reg      = rt_idx == '0 ? 32'h0 : regs[rt_idx];

`ifdef ID_WB_BYPASS_EN
    assign rs_data = (wb_en && wb_addr != '0 && wb_addr == rs_idx) ? wb_data : rs_reg;
    assign rt_data = (wb_en && wb_addr != '0 && wb_addr == rt_idx) ? wb_data : rt_reg;
`else
    assign rs_data = rs_reg;
    assign rt_data = rt_reg;
`endif
endmodule
